pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Owns the program counter and drives instruction fetch. Stores the PC,
//  issues one-at-a-time requests to instruction memory and hands each
//  {pc, instr} to decode over a valid/ready handshake.
//  Applies the wrap-at-MEM_SIZE next-PC rule and redirects on branches.
//  Sits between branch resolution and instruction memory, with decode downstream.
// PARAMETERS
//  PC_W      48   width of PC and memory address
//  MEM_SIZE  32   instruction memory depth in words; PC range is 0..MEM_SIZE-1
//  INSTR_W   32   instruction word width
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  imem_req     out  1        fetch request valid
//  imem_addr    out  PC_W     fetch word address; equals pc register
//  imem_gnt     in   1        memory accepts request this cycle (req&gnt = issue)
//  imem_rvalid  in   1        read data valid; arrives >=1 cycle after issue
//  imem_rdata   in   INSTR_W  read data
//  br_valid     in   1        redirect request, one-cycle pulse
//  br_target    in   PC_W     redirect word address
//  stall        in   1        decode-side hold; blocks handoff and new requests
//  if_valid     out  1        {if_pc, if_instr} valid to decode
//  if_pc        out  PC_W     PC of the presented instruction
//  if_instr     out  INSTR_W  presented instruction
//  if_ready     in   1        decode accepts; handoff = if_valid&if_ready&!stall
//  addr_err     out  1        one-cycle pulse: br_target >= MEM_SIZE
// BEHAVIOUR
//  - Reset: pc=0, state=REQ, if_valid=0, if_pc=0, if_instr=0, addr_err=0, drop=0.
//    imem_req=0 while rst=1.
//  - next(pc) = (pc+1 == MEM_SIZE) ? 0 : pc+1, computed at PC_W bits.
//    Example: pc=31 gives 0.
//  - FSM REQ: imem_req = !stall; imem_addr = pc.
//    On issue (req&gnt), go to WAIT.
//  - FSM WAIT: imem_req=0. On rvalid:
//    - drop=1: discard the data, clear drop, go to REQ.
//    - else: register if_pc<=pc, if_instr<=rdata, if_valid<=1; pc<=next(pc);
//      go to OUT.
//  - FSM OUT: if_valid=1, outputs stable. On handoff: if_valid<=0, go to REQ.
//    A new request can be issued on the cycle after handoff.
//  - Best-case issue-to-if_valid latency = memory latency + 1 cycle.
//  - Throughput: at most one instruction in flight.
//  - Branch (br_valid=1) has priority over all other events in that cycle:
//    - pc <= br_target if br_target < MEM_SIZE.
//    - Otherwise pc <= 0 and addr_err=1 next cycle.
//    - REQ without issue: go to REQ at the new pc.
//    - REQ with issue in the same cycle: the issued (old) address is stale;
//      drop<=1, go to WAIT.
//    - WAIT: drop<=1, stay in WAIT. If rvalid is in the same cycle, discard it
//      and go to REQ.
//    - OUT: if_valid<=0 next cycle (flush, even if handoff happens in the same
//      cycle); go to REQ.
//  - stall=1 in OUT freezes all outputs. stall does not cancel an issued
//    request; its data is still captured in WAIT.
//  - rst=1 in any state overrides everything. Any in-flight response is ignored
//    because the state returns to REQ with drop=0.
//    Memory must not return data for pre-reset requests after reset.
//  - pc never leaves 0..MEM_SIZE-1.
// STRUCTURE
//  - Shared package fetch_pkg holds PC_W, MEM_SIZE, INSTR_W defaults and the
//    state enum {REQ, WAIT, OUT}.
//  - One sub-module, pc_next_calc: combinational increment-and-wrap,
//    pc in, next out.
//  - Top level holds the FSM, pc, drop and output registers.
// TESTING
//  1. Reset, memory with 1-cycle gnt and rvalid, if_ready=1:
//     if_pc sequence 0,1,2,... to 31, then 0.
//     Each if_instr matches mem[if_pc].
//  2. Hold if_ready=0 for 5 cycles in OUT: if_valid, if_pc and if_instr stay
//     constant, imem_req stays 0. Then one handoff and fetch continues at pc+1.
//  3. br_valid with target 7 while in WAIT: the rvalid data is discarded,
//     the next imem_addr is 7, and the next if_pc is 7.
//  4. br_valid with target 12 in the same cycle as issue in REQ: the stale
//     response is not presented, and the first if_pc after that is 12.
//  5. br_target=40 (>= MEM_SIZE): addr_err pulses for 1 cycle,
//     the next imem_addr is 0.
//  6. Assert rst for 1 cycle during WAIT with stall=1:
//     if_valid=0 and pc=0, then the first if_pc after reset is 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default sizes.
// Imported by the PC fetch unit and its helpers.
package fetch_pkg;

    localparam int PC_W     = 48;
    localparam int MEM_SIZE = 32;
    localparam int INSTR_W  = 32;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        OUT
    } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Sequential next-PC: increment and wrap at MEM_SIZE.
// Purely combinational.
module pc_next_calc #(
    parameter int PC_W     = 48,
    parameter int MEM_SIZE = 32
) (
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] next
);

    localparam logic [PC_W-1:0] LP_MEM = PC_W'(MEM_SIZE);

    logic [PC_W-1:0] w_inc;

    assign w_inc = pc + PC_W'(1);
    assign next  = (w_inc == LP_MEM) ? '0 : w_inc;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher.
// Presents {pc, instr} to decode over valid/ready.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W     = fetch_pkg::PC_W,
    parameter int MEM_SIZE = fetch_pkg::MEM_SIZE,
    parameter int INSTR_W  = fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_valid,
    input  logic [PC_W-1:0]    br_target,
    input  logic               stall,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    input  logic               if_ready,
    output logic               addr_err
);

    localparam logic [PC_W-1:0] LP_MEM = PC_W'(MEM_SIZE);

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_drop;
    logic               r_if_valid;
    logic [PC_W-1:0]    r_if_pc;
    logic [INSTR_W-1:0] r_if_instr;
    logic               r_addr_err;

    logic [PC_W-1:0]    w_pc_next;
    logic               w_issue;
    logic               w_handoff;
    logic               w_tgt_ok;

    pc_next_calc #(
        .PC_W     (PC_W),
        .MEM_SIZE (MEM_SIZE)
    ) u_next (
        .pc   (r_pc),
        .next (w_pc_next)
    );

    assign imem_req  = (r_state == REQ) && !stall && !rst;
    assign imem_addr = r_pc;
    assign w_issue   = imem_req && imem_gnt;
    assign w_handoff = r_if_valid && if_ready && !stall;
    assign w_tgt_ok  = br_target < LP_MEM;

    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign addr_err  = r_addr_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= REQ;
            r_pc       <= '0;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            if (br_valid) begin
                // Redirect wins; any response already owed is stale.
                r_pc       <= w_tgt_ok ? br_target : '0;
                r_addr_err <= !w_tgt_ok;
                unique case (r_state)
                    REQ: begin
                        if (w_issue) begin
                            r_drop  <= 1'b1;
                            r_state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            r_drop  <= 1'b0;
                            r_state <= REQ;
                        end else begin
                            r_drop  <= 1'b1;
                        end
                    end
                    OUT: begin
                        r_if_valid <= 1'b0;
                        r_state    <= REQ;
                    end
                    default: r_state <= REQ;
                endcase
            end else begin
                unique case (r_state)
                    REQ: begin
                        if (w_issue) r_state <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (r_drop) begin
                                r_drop  <= 1'b0;
                                r_state <= REQ;
                            end else begin
                                r_if_pc    <= r_pc;
                                r_if_instr <= imem_rdata;
                                r_if_valid <= 1'b1;
                                r_pc       <= w_pc_next;
                                r_state    <= OUT;
                            end
                        end
                    end
                    OUT: begin
                        if (w_handoff) begin
                            r_if_valid <= 1'b0;
                            r_state    <= REQ;
                        end
                    end
                    default: r_state <= REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a 1-cycle memory model.
// Table-driven fetch sequence plus hand-written corner sequences.
module tb_pc_fetch_unit;

    localparam int PC_W = 48;
    localparam int IW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [IW-1:0]   imem_rdata;
    logic            br_valid;
    logic [PC_W-1:0] br_target;
    logic            stall;
    logic            if_valid;
    logic [PC_W-1:0] if_pc;
    logic [IW-1:0]   if_instr;
    logic            if_ready;
    logic            addr_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [IW-1:0]   instr;
    } vec_t;

    vec_t vecs [33];

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_ready    (if_ready),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [4:0] a);
        return {8'hA5, 3'b000, a, 11'h000, a};
    endfunction

    // Memory: grants always, answers exactly one cycle after issue.
    always @(posedge clk) begin
        if (rst) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            imem_rvalid <= imem_req & imem_gnt;
            imem_rdata  <= mem_word(imem_addr[4:0]);
        end
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout got if_valid=0 expected 1", nm);
        end
    endtask

    task automatic chk_out(input string nm,
                           input logic [PC_W-1:0] pc);
        chk({nm, "_pc"}, 64'(if_pc), 64'(pc));
        chk({nm, "_instr"}, 64'(if_instr),
            64'(mem_word(pc[4:0])));
    endtask

    initial begin
        for (int i = 0; i < 33; i++) begin
            vecs[i].pc    = (i == 32) ? '0 : PC_W'(i);
            vecs[i].instr = mem_word(vecs[i].pc[4:0]);
        end

        rst       = 1'b1;
        imem_gnt  = 1'b1;
        br_valid  = 1'b0;
        br_target = '0;
        stall     = 1'b0;
        if_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_if_pc", 64'(if_pc), 64'd0);
        chk("rst_if_instr", 64'(if_instr), 64'd0);
        chk("rst_addr_err", 64'(addr_err), 64'd0);
        chk("rst_imem_req", 64'(imem_req), 64'd0);

        rst = 1'b0;
        #1;
        chk("start_req", 64'(imem_req), 64'd1);
        chk("start_addr", 64'(imem_addr), 64'd0);

        // 1: straight-line fetch with wrap
        for (int i = 0; i < 33; i++) begin
            wait_valid("seq_valid");
            chk("seq_pc", 64'(if_pc), 64'(vecs[i].pc));
            chk("seq_instr", 64'(if_instr), 64'(vecs[i].instr));
            chk("seq_req_out", 64'(imem_req), 64'd0);
        end

        // 2: decode back-pressure holds outputs
        @(negedge clk);
        if_ready = 1'b0;
        wait_valid("hold_valid");
        chk_out("hold_first", 48'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_v", 64'(if_valid), 64'd1);
            chk_out("hold", 48'd1);
            chk("hold_req", 64'(imem_req), 64'd0);
        end
        if_ready = 1'b1;
        wait_valid("hold_next");
        chk_out("hold_next", 48'd2);

        // 3: branch while waiting, response arrives same cycle
        @(negedge clk);
        chk("b7_req", 64'(imem_req), 64'd1);
        chk("b7_addr0", 64'(imem_addr), 64'd3);
        @(negedge clk);
        br_valid  = 1'b1;
        br_target = 48'd7;
        @(negedge clk);
        br_valid  = 1'b0;
        chk("b7_novalid", 64'(if_valid), 64'd0);
        chk("b7_addr", 64'(imem_addr), 64'd7);
        wait_valid("b7_valid");
        chk_out("b7", 48'd7);

        // 4: branch on the issue cycle drops the stale response
        @(negedge clk);
        chk("b12_addr0", 64'(imem_addr), 64'd8);
        br_valid  = 1'b1;
        br_target = 48'd12;
        @(negedge clk);
        br_valid  = 1'b0;
        wait_valid("b12_valid");
        chk_out("b12", 48'd12);

        // 5: out-of-range target
        @(negedge clk);
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 48'd40;
        #1;
        chk("b40_stall_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        br_valid = 1'b0;
        stall    = 1'b0;
        chk("b40_err", 64'(addr_err), 64'd1);
        chk("b40_addr", 64'(imem_addr), 64'd0);
        @(negedge clk);
        chk("b40_err_clr", 64'(addr_err), 64'd0);
        wait_valid("b40_valid");
        chk_out("b40", 48'd0);

        // 6: reset during WAIT with stall
        @(negedge clk);
        chk("r_addr0", 64'(imem_addr), 64'd1);
        @(negedge clk);
        stall = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r_if_valid", 64'(if_valid), 64'd0);
        chk("r_pc", 64'(imem_addr), 64'd0);
        chk("r_stall_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        chk("r_still_idle", 64'(if_valid), 64'd0);
        stall = 1'b0;
        wait_valid("r_valid");
        chk_out("r", 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
